// File: rtl/cfg_chain_loader.sv
// rtl/cfg_chain_loader.sv - serial configuration chain loader with optional read-back verify
// Takes host words over valid/ready, shifts them MSB-first onto the chain and generates config_clk/config_en.
module cfg_chain_loader #(
  parameter int CHAIN_LEN = 200,
  parameter int WORD_W    = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           verify,
  input  logic [WORD_W-1:0]              word_in,
  input  logic                           word_valid,
  output logic                           word_ready,
  output logic                           cfg_data,
  output logic                           cfg_clk,
  output logic                           cfg_en,
  input  logic                           cfg_ret,
  output logic                           busy,
  output logic                           done,
  output logic                           error,
  output logic [$clog2(CHAIN_LEN+1)-1:0] bit_count
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    SHIFT_LO = 3'd2,
    SHIFT_HI = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] shreg;
  logic [WORD_W-1:0] shreg_next;
  logic [DIV_W-1:0]  div_cnt;
  logic [BIT_W-1:0]  bit_idx;
  logic              verify_q;
  logic              div_last;

  assign shreg_next = shreg << 1;
  assign div_last   = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      div_cnt    <= '0;
      bit_idx    <= '0;
      verify_q   <= 1'b0;
      word_ready <= 1'b0;
      cfg_data   <= 1'b0;
      cfg_clk    <= 1'b0;
      cfg_en     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      bit_count  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done       <= 1'b0;
          cfg_clk    <= 1'b0;
          cfg_en     <= 1'b0;
          word_ready <= 1'b0;
          if (start) begin
            verify_q   <= verify;
            error      <= 1'b0;
            bit_count  <= '0;
            busy       <= 1'b1;
            cfg_en     <= 1'b1;
            word_ready <= 1'b1;
            state      <= FETCH;
          end
        end

        // The chain clock is parked low here, so the host may stall indefinitely.
        FETCH: begin
          if (word_valid && word_ready) begin
            shreg      <= word_in;
            cfg_data   <= word_in[WORD_W-1];
            word_ready <= 1'b0;
            div_cnt    <= '0;
            bit_idx    <= '0;
            state      <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          if (div_last) begin
            if (verify_q && (cfg_ret != cfg_data)) begin
              error <= 1'b1;
            end
            cfg_clk <= 1'b1;
            div_cnt <= '0;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        SHIFT_HI: begin
          if (div_last) begin
            cfg_clk   <= 1'b0;
            div_cnt   <= '0;
            bit_count <= bit_count + CNT_W'(1);
            shreg     <= shreg_next;
            bit_idx   <= bit_idx + BIT_W'(1);
            // Last chain bit ends the pass even mid-word; leftover low bits are dropped.
            if (bit_count == CNT_W'(CHAIN_LEN - 1)) begin
              cfg_en <= 1'b0;
              done   <= 1'b1;
              state  <= DONE;
            end else if (bit_idx == BIT_W'(WORD_W - 1)) begin
              word_ready <= 1'b1;
              state      <= FETCH;
            end else begin
              cfg_data <= shreg_next[WORD_W-1];
              state    <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
